// File: rtl/regbank_arb.sv
// Shared register bank behind a round-robin write arbiter with short burst locking.
// One registered read port. The read returns the pre-write value on a same-edge collision.
module regbank_arb #(
    parameter int NREQ      = 4,
    parameter int NREG      = 8,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    localparam int AW       = $clog2(NREG),
    localparam int IW       = $clog2(NREQ)
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VALID,
    input  logic [NREQ-1:0]      REQ_LOCK,
    input  logic [NREQ*AW-1:0]   REQ_ADDR,
    input  logic [NREQ*DW-1:0]   REQ_DATA,
    output logic [NREQ-1:0]      REQ_READY,
    output logic [IW-1:0]        GRANT_ID,
    output logic                 BUSY,
    input  logic [AW-1:0]        RD_ADDR,
    output logic [DW-1:0]        RD_DATA
);

    localparam int CW = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   prio;
    logic [IW-1:0]   prio_next;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   owner_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            grant_any;
    logic [IW-1:0]   grant_id;
    logic [IW-1:0]   cand;
    int              idx;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_lock;
    logic [DW-1:0]   bank [NREG];

    function automatic logic [IW-1:0] next_index(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // In IDLE the first valid requester at or after prio wins; in LOCKED only the owner can win.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        if (state == IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                idx  = (int'(prio) + k) % NREQ;
                cand = IW'(idx);
                if (!grant_any && REQ_VALID[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end else if (REQ_VALID[owner]) begin
            grant_any = 1'b1;
            grant_id  = owner;
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (grant_any) begin
            REQ_READY[grant_id] = 1'b1;
        end
    end

    assign GRANT_ID = grant_id;
    assign BUSY     = (state == LOCKED);
    assign wr_addr  = REQ_ADDR[grant_id*AW +: AW];
    assign wr_data  = REQ_DATA[grant_id*DW +: DW];
    assign wr_lock  = REQ_LOCK[grant_id];

    // A lock is released by an unlocked beat, by reaching MAX_BURST, or by one idle owner cycle.
    always_comb begin
        state_next = state;
        prio_next  = prio;
        owner_next = owner;
        count_next = count;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    if (wr_lock && (MAX_BURST > 1)) begin
                        state_next = LOCKED;
                        owner_next = grant_id;
                        count_next = CW'(1);
                    end else begin
                        prio_next = next_index(grant_id);
                    end
                end
            end
            LOCKED: begin
                if (grant_any) begin
                    count_next = count + 1'b1;
                    if (!wr_lock || (count_next == CW'(MAX_BURST))) begin
                        state_next = IDLE;
                        prio_next  = next_index(owner);
                    end
                end else begin
                    state_next = IDLE;
                    prio_next  = next_index(owner);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= IDLE;
            prio    <= '0;
            owner   <= '0;
            count   <= '0;
            RD_DATA <= '0;
            for (int r = 0; r < NREG; r++) begin
                bank[r] <= '0;
            end
        end else begin
            state   <= state_next;
            prio    <= prio_next;
            owner   <= owner_next;
            count   <= count_next;
            RD_DATA <= bank[RD_ADDR];
            if (grant_any) begin
                bank[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regbank_arb.sv
// Scoreboard bench for regbank_arb: stimulus queues expected grant/read results,
// a negedge monitor pops and compares them.
module tb_regbank_arb;

    typedef struct packed {
        logic [3:0] ready;
        logic [1:0] gid;
        logic       busy;
    } grant_t;

    logic         ck = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_lock;
    logic [11:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [1:0]   grant_id;
    logic         busy;
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data;

    logic [2:0]   addr_r [4];
    logic [31:0]  data_r [4];

    grant_t       grant_q [$];
    logic [31:0]  rd_q [$];
    grant_t       mon_exp;
    logic [31:0]  mon_rd;
    logic         mon_en = 1'b0;
    logic         rd_chk = 1'b0;
    logic         rd_pending = 1'b0;
    int           checks = 0;
    int           errors = 0;
    int           grant_seq = 0;
    int           rd_seq = 0;

    regbank_arb dut (
        .CK       (ck),
        .RST      (rst),
        .REQ_VALID(req_valid),
        .REQ_LOCK (req_lock),
        .REQ_ADDR (req_addr),
        .REQ_DATA (req_data),
        .REQ_READY(req_ready),
        .GRANT_ID (grant_id),
        .BUSY     (busy),
        .RD_ADDR  (rd_addr),
        .RD_DATA  (rd_data)
    );

    always #5 ck = ~ck;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_addr[i*3 +: 3]   = addr_r[i];
            req_data[i*32 +: 32] = data_r[i];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    always @(posedge ck) rd_pending <= rd_chk;

    // Reads resolve one edge after issue; grant outputs are checked in the cycle they are driven.
    always @(negedge ck) begin
        if (mon_en) begin
            if (grant_q.size() == 0) begin
                check_output("grant_q_underflow", 32'd1, 32'd0);
            end else begin
                mon_exp = grant_q.pop_front();
                check_output($sformatf("grant#%0d {ready,id,busy}", grant_seq),
                             32'({req_ready, grant_id, busy}), 32'(mon_exp));
                grant_seq++;
            end
        end
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                check_output("rd_q_underflow", 32'd1, 32'd0);
            end else begin
                mon_rd = rd_q.pop_front();
                check_output($sformatf("rd_data#%0d", rd_seq), rd_data, mon_rd);
                rd_seq++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge ck);
        #1;
        mon_en = 1'b0;
        rd_chk = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
        addr_r[i] = a;
        data_r[i] = d;
    endtask

    task automatic issue_read(input logic [2:0] a, input logic [31:0] expected);
        rd_addr = a;
        rd_chk  = 1'b1;
        rd_q.push_back(expected);
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic [3:0] lock,
                                  input logic [3:0] ready, input logic [1:0] gid, input logic bsy);
        req_valid = valid;
        req_lock  = lock;
        grant_q.push_back('{ready: ready, gid: gid, busy: bsy});
        mon_en = 1'b1;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        rd_addr   = '0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 3'd0, 32'd0);
        end
        next_cycle();
        issue_read(3'd0, 32'd0);
        next_cycle();
        rst = 1'b0;

        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single write, then read back every address
        set_req(0, 3'd3, 32'hDEADBEEF);
        apply_stimulus(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        issue_read(3'd3, 32'hDEADBEEF);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            if (a != 3) begin
                issue_read(3'(a), 32'd0);
                next_cycle();
            end
        end

        // Round robin, prio starts at 1 after the first grant to requester 0
        for (int i = 0; i < 4; i++) begin
            set_req(i, 3'(i), 32'hA000_0000 + 32'(i));
        end
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(4'b1111, 4'b0000, 4'(1 << ((c + 1) % 4)), 2'((c + 1) % 4), 1'b0);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            issue_read(3'(i), 32'hA000_0000 + 32'(i));
            next_cycle();
        end

        // Burst lock capped at MAX_BURST, requester 2 served before requester 1 relocks
        set_req(1, 3'd1, 32'h1111_0001);
        set_req(2, 3'd2, 32'h2222_0002);
        apply_stimulus(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b0);
        apply_stimulus(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1);
        apply_stimulus(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1);
        apply_stimulus(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1);
        apply_stimulus(4'b0110, 4'b0010, 4'b0100, 2'd2, 1'b0);
        apply_stimulus(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0);
        apply_stimulus(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1);

        // Owner idles one cycle: lock drops and the pending requester wins next
        set_req(2, 3'd2, 32'h2222_4444);
        set_req(3, 3'd3, 32'h3333_0003);
        apply_stimulus(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0);
        apply_stimulus(4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1);
        apply_stimulus(4'b1100, 4'b0000, 4'b1000, 2'd3, 1'b0);
        issue_read(3'd0, 32'hA000_0000);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        issue_read(3'd1, 32'h1111_0001);
        next_cycle();
        issue_read(3'd2, 32'h2222_4444);
        next_cycle();
        issue_read(3'd3, 32'h3333_0003);
        next_cycle();

        // Same-edge write and read returns the old value first
        set_req(0, 3'd5, 32'h0000_0001);
        issue_read(3'd5, 32'd0);
        apply_stimulus(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        issue_read(3'd5, 32'h0000_0001);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Reset during a locked beat; afterwards prio is back at 0
        set_req(1, 3'd6, 32'hCAFE_F00D);
        apply_stimulus(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0);
        set_req(1, 3'd7, 32'hBEEF_0007);
        rst = 1'b1;
        apply_stimulus(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1);
        rst = 1'b0;
        issue_read(3'd7, 32'd0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        set_req(0, 3'd4, 32'h0000_0044);
        set_req(3, 3'd3, 32'h0000_0099);
        issue_read(3'd6, 32'd0);
        apply_stimulus(4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0);
        issue_read(3'd4, 32'h0000_0044);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        next_cycle();
        next_cycle();

        check_output("grant_q_leftover", 32'(grant_q.size()), 32'd0);
        check_output("rd_q_leftover", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
